// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - issue control for RV32M ops on a shared iterative mul/div unit
// Handles divide special cases locally, bounds unit latency with a timeout, and honours flush/freeze.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mul_inst,
  input  logic        div_inst,
  input  logic [1:0]  op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  input  logic        freeze,
  output logic        unit_start,
  output logic        unit_is_div,
  output logic [1:0]  unit_sel,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_res,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res,
  output logic [4:0]  res_rd,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        pend_q;
  logic [31:0] pend_res_q;
  logic [4:0]  rd_q;

  logic        req;
  logic        is_div;
  logic        div_zero;
  logic        div_ovf;
  logic        fast;
  logic        accept;
  logic        run_done;
  logic        run_to;
  logic [31:0] fast_res;
  logic [31:0] done_res;

  assign req = mul_inst | div_inst;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    run_done = 1'b0;
    run_to   = 1'b0;
    is_div   = div_inst & ~mul_inst;
    div_zero = (op_b == 32'd0);
    // Signed overflow only applies to DIV (00) and REM (10)
    div_ovf  = ~op_sel[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    fast     = is_div & (div_zero | div_ovf);
    if (div_zero) fast_res = op_sel[1] ? op_a : 32'hFFFF_FFFF;
    else          fast_res = op_sel[1] ? 32'd0 : 32'h8000_0000;
    done_res = pend_q ? pend_res_q : unit_res;
    stall    = req & (state_q != DONE) & ~flush;

    case (state_q)
      IDLE: begin
        if (req && !freeze && !flush) begin
          accept  = 1'b1;
          state_d = fast ? DONE : RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!freeze) begin
          if (unit_done || pend_q) begin
            run_done = 1'b1;
            state_d  = DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            run_to  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush || !freeze) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      cnt_q       <= 8'd0;
      pend_q      <= 1'b0;
      pend_res_q  <= 32'd0;
      rd_q        <= 5'd0;
      unit_start  <= 1'b0;
      unit_is_div <= 1'b0;
      unit_sel    <= 2'd0;
      unit_a      <= 32'd0;
      unit_b      <= 32'd0;
      res_valid   <= 1'b0;
      res         <= 32'd0;
      res_rd      <= 5'd0;
      timeout_err <= 1'b0;
    end else begin
      // The unit sees start for one cycle even if the pipeline freezes right away
      unit_start <= accept & ~fast;

      if (accept) begin
        unit_a      <= op_a;
        unit_b      <= op_b;
        unit_sel    <= op_sel;
        unit_is_div <= is_div;
        rd_q        <= op_rd;
        cnt_q       <= 8'd0;
        pend_q      <= 1'b0;
        if (fast) begin
          res       <= fast_res;
          res_valid <= 1'b1;
          res_rd    <= op_rd;
        end
      end

      if (state_q == RUN) begin
        if (flush) begin
          cnt_q  <= 8'd0;
          pend_q <= 1'b0;
        end else if (freeze) begin
          if (unit_done && !pend_q) begin
            pend_q     <= 1'b1;
            pend_res_q <= unit_res;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
          if (run_done) begin
            res       <= done_res;
            res_valid <= 1'b1;
            res_rd    <= rd_q;
            pend_q    <= 1'b0;
          end else if (run_to) begin
            res         <= 32'd0;
            res_valid   <= 1'b1;
            res_rd      <= rd_q;
            timeout_err <= 1'b1;
          end
        end
      end

      if (state_q == DONE && (flush || !freeze)) begin
        res_valid <= 1'b0;
        res_rd    <= 5'd0;
        cnt_q     <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb/tb_muldiv_issue_ctrl.sv - self-checking bench for muldiv_issue_ctrl
// Acts as the decode stage and the shared unit; results come from an arithmetic RV32M model.
module tb_muldiv_issue_ctrl;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        mul_inst = 1'b0, div_inst = 1'b0;
  logic [1:0]  op_sel = 2'd0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic [4:0]  op_rd = 5'd0;
  logic        flush = 1'b0, freeze = 1'b0;
  logic        unit_start, unit_is_div;
  logic [1:0]  unit_sel;
  logic [31:0] unit_a, unit_b;
  logic        unit_done = 1'b0;
  logic [31:0] unit_res = 32'd0;
  logic        stall, res_valid, timeout_err;
  logic [31:0] res;
  logic [4:0]  res_rd;

  int checks = 0;
  int failures = 0;
  logic te_exp = 1'b0;

  muldiv_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Rst(Rst),
    .mul_inst(mul_inst), .div_inst(div_inst), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .flush(flush), .freeze(freeze),
    .unit_start(unit_start), .unit_is_div(unit_is_div), .unit_sel(unit_sel),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_res(unit_res),
    .stall(stall), .res_valid(res_valid), .res(res), .res_rd(res_rd),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M architectural result
  function automatic logic [31:0] ref_res(input logic is_mul, input logic [1:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (is_mul) begin
      case (sel)
        2'd0: begin up = ua * ub; return up[31:0]; end
        2'd1: begin sp = sa * sb; return sp[63:32]; end
        2'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
        default: begin up = ua * ub; return up[63:32]; end
      endcase
    end
    case (sel)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One instruction issued and held until res_valid; lat<0 means the unit never answers.
  task automatic do_op(input logic m, input logic d, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat);
    logic isdiv, fast;
    logic [31:0] exp;
    int exp_n, got_n, starts;
    isdiv = d & ~m;
    fast  = isdiv && (b == 0 || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp   = (lat < 0 && !fast) ? 32'd0 : ref_res(~isdiv, sel, a, b);
    exp_n = fast ? 1 : (lat < 0 ? 1 + TIMEOUT : 2 + lat);
    mul_inst = m; div_inst = d; op_sel = sel; op_a = a; op_b = b; op_rd = rd;
    #1;
    chk("stall_on_req", stall, 1);
    starts = 0;
    got_n = 0;
    for (int n = 1; n <= TIMEOUT + 20 && got_n == 0; n++) begin
      tick();
      unit_done = 1'b0;
      if (unit_start) begin
        starts++;
        chk("unit_a", unit_a, a);
        chk("unit_b", unit_b, b);
        chk("unit_sel", unit_sel, sel);
        chk("unit_is_div", unit_is_div, isdiv);
      end
      if (!fast && lat >= 0 && n == 1 + lat) begin
        unit_done = 1'b1;
        unit_res  = exp;
      end
      if (res_valid) begin
        got_n = n;
        chk("res", res, exp);
        chk("res_rd", res_rd, rd);
        chk("stall_done", stall, 0);
        mul_inst = 1'b0; div_inst = 1'b0;
      end else begin
        chk("stall_busy", stall, 1);
      end
    end
    mul_inst = 1'b0; div_inst = 1'b0; unit_done = 1'b0;
    if (lat < 0 && !fast) te_exp = 1'b1;
    chk("latency", got_n, exp_n);
    chk("start_count", starts, fast ? 0 : 1);
    chk("timeout_err", timeout_err, te_exp);
    tick();
    chk("res_valid_one_cycle", res_valid, 0);
    chk("res_hold", res, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic m, d;
    int mode;

    repeat (3) tick();
    chk("rst_unit_start", unit_start, 0);
    chk("rst_unit_is_div", unit_is_div, 0);
    chk("rst_unit_sel", unit_sel, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_stall", stall, 0);
    Rst = 1'b1;
    tick();

    do_op(1, 0, 2'b00, 32'd7, 32'd6, 5'd9, 4);
    do_op(1, 0, 2'b00, 32'd3, 32'd5, 5'd1, 0);
    do_op(0, 1, 2'b01, 32'd5, 32'd0, 5'd2, 3);
    do_op(0, 1, 2'b10, 32'd5, 32'd0, 5'd3, 3);
    do_op(0, 1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 3);
    do_op(0, 1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 3);
    do_op(0, 1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1);
    do_op(1, 1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 2);

    // Flush two cycles into RUN, then a late unit_done
    mul_inst = 1'b1; op_sel = 2'b00; op_a = 32'd11; op_b = 32'd13; op_rd = 5'd8;
    tick();
    chk("flush_start", unit_start, 1);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0; mul_inst = 1'b0;
    unit_done = 1'b1; unit_res = 32'd143;
    chk("flush_no_valid0", res_valid, 0);
    tick();
    unit_done = 1'b0;
    chk("flush_no_valid1", res_valid, 0);
    chk("flush_no_start", unit_start, 0);
    tick();
    chk("flush_no_valid2", res_valid, 0);
    do_op(1, 0, 2'b01, 32'hFFFF_FFF0, 32'd3, 5'd10, 2);

    // Freeze during RUN with unit_done arriving mid-freeze
    div_inst = 1'b1; op_sel = 2'b01; op_a = 32'd100; op_b = 32'd7; op_rd = 5'd11;
    tick();
    chk("frz_start", unit_start, 1);
    tick();
    freeze = 1'b1;
    tick();
    unit_done = 1'b1; unit_res = 32'h1234;
    tick();
    unit_done = 1'b0; unit_res = 32'hDEAD;
    chk("frz_no_valid0", res_valid, 0);
    tick();
    chk("frz_no_valid1", res_valid, 0);
    tick();
    freeze = 1'b0;
    chk("frz_no_valid2", res_valid, 0);
    tick();
    chk("frz_valid", res_valid, 1);
    chk("frz_res", res, 32'h1234);
    chk("frz_rd", res_rd, 5'd11);
    div_inst = 1'b0;
    tick();
    chk("frz_valid_clear", res_valid, 0);

    // Unit never answers
    do_op(1, 0, 2'b11, 32'd3, 32'd4, 5'd12, -1);

    for (int i = 0; i < 20; i++) begin
      m = 1'($urandom % 2);
      d = m ? 1'($urandom % 2) : 1'b1;
      mode = int'($urandom % 4);
      ra = $urandom;
      rb = $urandom;
      if (mode == 0) rb = 32'd0;
      if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      do_op(m, d, 2'($urandom % 4), ra, rb, 5'($urandom % 32), int'($urandom_range(0, 6)));
    end

    // Reset mid-RUN abandons the op and clears the sticky error
    mul_inst = 1'b1; op_sel = 2'b00; op_a = 32'd2; op_b = 32'd2; op_rd = 5'd13;
    tick();
    tick();
    Rst = 1'b0;
    tick();
    Rst = 1'b1; mul_inst = 1'b0;
    unit_done = 1'b1; unit_res = 32'd4;
    te_exp = 1'b0;
    chk("rrun_no_valid0", res_valid, 0);
    chk("rrun_timeout_err", timeout_err, 0);
    chk("rrun_unit_a", unit_a, 0);
    tick();
    unit_done = 1'b0;
    chk("rrun_no_valid1", res_valid, 0);
    chk("rrun_res", res, 0);
    tick();
    chk("rrun_no_valid2", res_valid, 0);
    do_op(0, 1, 2'b11, 32'd29, 32'd5, 5'd14, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_issue_ctrl.md
MULDIV_ISSUE_CTRL -- requirements
Module: muldiv_issue_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: TIMEOUT, default 64, max RUN cycles before abort (2..255).
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 Rst  in  1  synchronous active-low reset.
REQ-005 mul_inst, div_inst  in  1 each  decoded M-extension request from decode stage.
REQ-006 op_sel  in  2  MUL:00 MUL,01 MULH,10 MULHSU,11 MULHU; DIV:00 DIV,01 DIVU,10 REM,11 REMU.
REQ-007 op_a, op_b  in  32 each  forwarded rs1/rs2 values; op_rd  in  5  destination.
REQ-008 flush  in  1  branch/trap kill; freeze  in  1  dbg/mem_hold/f_stall pipeline freeze.
REQ-009 unit_start  out  1; unit_is_div  out  1; unit_sel  out  2; unit_a, unit_b  out  32 each  to shared iterative unit.
REQ-010 unit_done  in  1; unit_res  in  32  from shared unit.
REQ-011 stall  out  1; res_valid  out  1; res  out  32; res_rd  out  5; timeout_err  out  1 sticky.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; state, counter and all outputs except stall registered.
REQ-013 IDLE accept when (mul_inst|div_inst) & !freeze & !flush: latch op_a/op_b/op_sel/op_rd, unit_is_div=div_inst & !mul_inst (mul priority if both).
REQ-014 On accept, div with op_b==0 SHALL go to DONE without unit_start: DIV/DIVU res=0xFFFFFFFF, REM/REMU res=op_a.
REQ-015 On accept, DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF SHALL go to DONE without unit_start: DIV res=0x80000000, REM res=0.
REQ-016 Otherwise accept -> RUN; unit_start=1 for exactly the first RUN cycle, unit_a/unit_b/unit_sel/unit_is_div held stable throughout RUN.
REQ-017 RUN: 8-bit counter cleared on entry, +1 per unfrozen cycle; unit_done sampled every RUN cycle including the unit_start cycle.
REQ-018 RUN & unit_done: res<=unit_res -> DONE; min latency accept-to-res_valid = 2 cycles.
REQ-019 RUN & counter==TIMEOUT-1 & !unit_done: timeout_err<=1, res<=0 -> DONE; unit_done same cycle wins.
REQ-020 DONE: res_valid=1 and res_rd=latched rd for exactly one cycle, then IDLE; res held until next DONE.
REQ-021 stall = (mul_inst|div_inst) & (state!=DONE) & !flush, combinational.
REQ-022 flush in RUN or DONE: -> IDLE next cycle, no res_valid, counter cleared, late unit_done ignored in IDLE.
REQ-023 freeze: state, counter, outputs held; unit_done during frozen RUN SHALL set a pending flag, consumed as unit_done once freeze drops, unit_res captured at pulse.
REQ-024 flush and freeze together: flush wins.
REQ-025 New request in DONE cycle not accepted; accepted earliest next IDLE cycle.

Reset
REQ-026 Rst=0 at clock edge: state=IDLE, counter=0, pending=0, unit_start=0, unit_is_div=0, unit_sel=0, unit_a=unit_b=0, res_valid=0, res=0, res_rd=0, timeout_err=0.
REQ-027 Reset mid-RUN SHALL abandon operation, no res_valid; later unit_done ignored.

Verification
REQ-028 MUL a=7,b=6,sel=00; unit_done 4 cycles after start, unit_res=42 -> unit_start 1 cycle, stall high until DONE, res_valid 1 cycle, res=42, res_rd=op_rd.
REQ-029 DIVU a=5,b=0,sel=01 -> no unit_start, DONE next cycle, res=0xFFFFFFFF; REM a=5,b=0 -> res=5.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> res=0x80000000, no unit_start; REM same operands -> res=0.
REQ-031 Unit never asserts unit_done, TIMEOUT=64 -> DONE after 64 RUN cycles, res=0, timeout_err=1 and stays until Rst=0.
REQ-032 flush 2 cycles into RUN, then unit_done -> no res_valid, state IDLE, next request accepted normally.
REQ-033 freeze asserted in RUN with unit_done pulse mid-freeze, unit_res=0x1234 -> res_valid only after freeze release, res=0x1234.
